fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                       |
// | Brief    : Instruction fetch stage: PC, imem handshake, IF/ID load control. |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        ena_ifid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_hold_inst, w_hold_inst_nxt;
  logic [31:0] r_hold_pc, w_hold_pc_nxt;
  logic [31:0] r_stale_addr, w_stale_addr_nxt;
  logic [31:0] w_redir_pc;
  logic        w_req, w_ena;
  logic [31:0] w_addr, w_inst, w_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_hold_inst  <= 32'h0;
      r_hold_pc    <= 32'h0;
      r_stale_addr <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold_inst  <= w_hold_inst_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_stale_addr <= w_stale_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_hold_inst_nxt  = r_hold_inst;
    w_hold_pc_nxt    = r_hold_pc;
    w_stale_addr_nxt = r_stale_addr;
    w_req            = 1'b0;
    w_addr           = r_pc;
    w_ena            = 1'b0;
    w_inst           = 32'h0;
    w_pc             = 32'h0;

    // Redirect wins in every state: flush IF/ID with a bubble tagged by the target.
    if (redirect) begin
      w_ena    = 1'b1;
      w_inst   = NOP_INST;
      w_pc     = w_redir_pc;
      w_pc_nxt = w_redir_pc;
    end

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (redirect) begin
          if (!imem_ack) begin
            w_stale_addr_nxt = r_pc;
            w_state_nxt      = S_DROP;
          end
        end else if (imem_ack) begin
          w_pc_nxt = r_pc + 32'd4;
          if (stall) begin
            w_hold_inst_nxt = imem_rdata;
            w_hold_pc_nxt   = r_pc;
            w_state_nxt     = S_HOLD;
          end else begin
            w_ena  = 1'b1;
            w_inst = imem_rdata;
            w_pc   = r_pc;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_ena       = 1'b1;
          w_inst      = r_hold_inst;
          w_pc        = r_hold_pc;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // Keep the abandoned address on the bus until memory retires it.
        w_req  = 1'b1;
        w_addr = r_stale_addr;
        if (imem_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (!rst_n) begin
      w_req  = 1'b0;
      w_ena  = 1'b0;
      w_inst = 32'h0;
      w_pc   = 32'h0;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_addr;
  assign ena_ifid  = w_ena;
  assign inst_out  = w_inst;
  assign pc_out    = w_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                    |
// | Brief    : Randomized self-checking bench for fetch_unit vs. a stream model.|
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;
  localparam logic [31:0] C_KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        ena_ifid;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(C_RESET_PC), .NOP_INST(C_NOP)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .ena_ifid   (ena_ifid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Fetch-stream model: next address to fetch, instructions waiting for the
  // decoder, and whether an abandoned read is still in flight.
  bit          m_started;
  logic [31:0] m_next_pc;
  logic [63:0] m_waiting[$];
  bit          m_in_flight;
  logic [31:0] m_in_flight_addr;

  task automatic model_reset();
    m_started   = 1'b0;
    m_next_pc   = C_RESET_PC;
    m_waiting.delete();
    m_in_flight = 1'b0;
    m_in_flight_addr = 32'h0;
  endtask

  // One clock cycle: called just after a posedge, returns just after the next.
  task automatic cycle(input bit a, input bit s, input bit r, input logic [31:0] rpc);
    logic        e_req;
    logic [31:0] e_addr, e_inst, e_pc, tgt, data;
    logic        e_ena;
    tgt    = {rpc[31:2], 2'b00};
    e_req  = m_started && (m_waiting.size() == 0);
    e_addr = m_in_flight ? m_in_flight_addr : m_next_pc;
    data   = (a && e_req) ? (e_addr ^ C_KEY) : $urandom;
    imem_ack = a; stall = s; redirect = r; redirect_pc = rpc; imem_rdata = data;

    e_ena = 1'b0; e_inst = 32'h0; e_pc = 32'h0;
    if (r) begin
      e_ena = 1'b1; e_inst = C_NOP; e_pc = tgt;
    end
    if (!m_started) begin
      m_started = 1'b1;
      if (r) m_next_pc = tgt;
    end else if (m_waiting.size() != 0) begin
      if (r) begin
        m_waiting.delete();
        m_next_pc = tgt;
      end else if (!s) begin
        e_ena = 1'b1;
        {e_inst, e_pc} = m_waiting.pop_front();
      end
    end else if (m_in_flight) begin
      if (r) m_next_pc = tgt;
      if (a) m_in_flight = 1'b0;
    end else if (r) begin
      if (!a) begin
        m_in_flight = 1'b1;
        m_in_flight_addr = m_next_pc;
      end
      m_next_pc = tgt;
    end else if (a) begin
      if (s) m_waiting.push_back({data, m_next_pc});
      else begin
        e_ena = 1'b1; e_inst = data; e_pc = m_next_pc;
      end
      m_next_pc = m_next_pc + 32'd4;
    end

    #2;
    check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) check("imem_addr", imem_addr, e_addr);
    check("ena_ifid", {31'b0, ena_ifid}, {31'b0, e_ena});
    check("inst_out", inst_out, e_inst);
    check("pc_out", pc_out, e_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},  {31'b0, imem_req}, 32'h0);
    check({tag, "_ena"},  {31'b0, ena_ifid}, 32'h0);
    check({tag, "_inst"}, inst_out, 32'h0);
    check({tag, "_pc"},   pc_out, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("por");
    do_reset();

    // Zero-wait streaming from reset
    repeat (10) cycle(1, 0, 0, 32'h0);

    // Stall on the ack of address 0x8, three stalled cycles
    do_reset();
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 0, 32'h0);
    cycle(0, 1, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 32'h0);

    // Redirect during a wait, slow ack drains the stale read
    cycle(0, 0, 1, 32'h0000_0103);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(1, 0, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 32'h0);

    // Redirect, stall and ack in the same cycle
    cycle(1, 1, 1, 32'h0000_0222);
    repeat (3) cycle(1, 0, 0, 32'h0);

    // Redirect inside DROP, then PC wrap at the top of the address space
    cycle(0, 0, 1, 32'h0000_0300);
    cycle(0, 0, 1, 32'hFFFF_FFFE);
    cycle(1, 0, 0, 32'h0);
    repeat (4) cycle(1, 0, 0, 32'h0);

    // Reset asserted mid-DROP with a stray ack around the reset edge
    cycle(0, 0, 1, 32'h0000_0200);
    imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    #1;
    check("drop_req", {31'b0, imem_req}, 32'h1);
    check("drop_addr", imem_addr, m_in_flight_addr);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("in_rst");
    rst_n = 1'b1;
    model_reset();
    repeat (5) cycle(1, 0, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit a, s, r;
      a = ($urandom_range(99, 0) < 65);
      s = ($urandom_range(99, 0) < 30);
      r = ($urandom_range(99, 0) < 7);
      cycle(a, s, r, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
